// File: rtl/cas_player.sv
// cas_player: captures a .CAS image from the HPS download bus into block RAM
// and replays it as a pulse-encoded tape waveform (clock pulse every cell,
// extra data pulse at mid-cell for 1-bits, MSB first, ascending addresses).
module cas_player #(
    parameter int ADDR_W       = 15,
    parameter int CELL_CYCLES  = 35714,
    parameter int PULSE_CYCLES = 4000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dn_go,
    input  logic              dn_wr,
    input  logic [24:0]       dn_addr,
    input  logic [7:0]        dn_data,
    input  logic              play,
    input  logic              rewind,
    output logic              tape,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   length
);

    localparam int CNT_W = (CELL_CYCLES > 1) ? $clog2(CELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(CELL_CYCLES / 2);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CELL_CYCLES / 2 + PULSE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        CELL,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   ptr_reg, ptr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        bitn_reg, bitn_next;
    logic [7:0]        shift_reg, shift_next;
    logic [ADDR_W:0]   length_reg, length_next;
    logic              tape_reg, tape_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              dn_go_reg;

    logic [7:0]        mem [0:(2**ADDR_W)-1];
    logic [7:0]        rd_data;

    logic              go_rise;
    logic              addr_ok;
    logic              wr_en;
    logic [ADDR_W:0]   addr_p1;
    logic [ADDR_W:0]   ptr_inc;
    logic              pulse_on;

    assign go_rise = dn_go & ~dn_go_reg;
    // Bytes whose address does not fit in the image RAM are silently dropped.
    assign addr_ok = ((dn_addr >> ADDR_W) == 25'd0);
    assign wr_en   = dn_go & dn_wr & addr_ok;
    assign addr_p1 = {1'b0, dn_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1);
    assign ptr_inc = ptr_reg + (ADDR_W+1)'(1);

    // Clock pulse at the start of every cell, data pulse at mid-cell for 1-bits.
    assign pulse_on = (cnt_reg < PULSE_END) ||
                      (shift_reg[7] && (cnt_reg >= HALF) && (cnt_reg < HALF_END));

    assign tape   = tape_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign length = length_reg;

    // Image RAM write port, written straight from the download bus.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[dn_addr[ADDR_W-1:0]] <= dn_data;
        end
    end

    // Registered RAM read port; the value is consumed in LOAD, one cycle after FETCH.
    always_ff @(posedge clock) begin
        rd_data <= mem[ptr_reg[ADDR_W-1:0]];
    end

    // Image length tracks the highest written address + 1; a new download restarts it.
    always_comb begin
        length_next = go_rise ? '0 : length_reg;
        if (wr_en && (addr_p1 > length_next)) begin
            length_next = addr_p1;
        end
    end

    // Next-state and output decode; download and rewind override playback.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        bitn_next  = bitn_reg;
        shift_next = shift_reg;
        tape_next  = 1'b0;
        busy_next  = 1'b0;
        done_next  = 1'b0;

        if (dn_go || rewind) begin
            state_next = IDLE;
            ptr_next   = '0;
        end else begin
            tape_next = (state_reg == CELL) && play && pulse_on;
            busy_next = (state_reg == FETCH) || (state_reg == LOAD) || (state_reg == CELL);
            done_next = (state_reg == DONE);

            case (state_reg)
                IDLE: begin
                    if (play && (length_reg != '0) && (ptr_reg < length_reg)) begin
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    state_next = LOAD;
                end
                LOAD: begin
                    shift_next = rd_data;
                    bitn_next  = 3'd7;
                    cnt_next   = '0;
                    state_next = CELL;
                end
                CELL: begin
                    // With play low everything is frozen so the cell resumes in place.
                    if (play) begin
                        if (cnt_reg == CNT_LAST) begin
                            if (bitn_reg != 3'd0) begin
                                bitn_next  = bitn_reg - 3'd1;
                                shift_next = {shift_reg[6:0], 1'b0};
                                cnt_next   = '0;
                            end else begin
                                ptr_next   = ptr_inc;
                                state_next = (ptr_inc < length_reg) ? FETCH : DONE;
                            end
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            cnt_reg    <= '0;
            bitn_reg   <= 3'd0;
            shift_reg  <= 8'd0;
            length_reg <= '0;
            tape_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            dn_go_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            bitn_reg   <= bitn_next;
            shift_reg  <= shift_next;
            length_reg <= length_next;
            tape_reg   <= tape_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            dn_go_reg  <= dn_go;
        end
    end

endmodule

// File: tb/tb_cas_player.sv
// Directed testbench for cas_player with short cells (16 cycles, 3-cycle pulses).
module tb_cas_player;

    localparam int ADDR_W = 15;
    localparam int CELL   = 16;
    localparam int PULSE  = 3;
    localparam int BYTE_T = 8 * CELL + 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              dn_go = 1'b0;
    logic              dn_wr = 1'b0;
    logic [24:0]       dn_addr = '0;
    logic [7:0]        dn_data = '0;
    logic              play = 1'b0;
    logic              rewind = 1'b0;
    logic              tape;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   length;

    int tests_run = 0;
    int fails = 0;

    logic [7:0] img [0:3];
    int         img_n = 0;

    cas_player #(
        .ADDR_W(ADDR_W),
        .CELL_CYCLES(CELL),
        .PULSE_CYCLES(PULSE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .dn_go(dn_go),
        .dn_wr(dn_wr),
        .dn_addr(dn_addr),
        .dn_data(dn_data),
        .play(play),
        .rewind(rewind),
        .tape(tape),
        .busy(busy),
        .done(done),
        .length(length)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected tape level t cycles after the edge that sampled play (uninterrupted run).
    function automatic logic exp_tape(input int t);
        int u, b, r, k, c;
        logic bv;
        if (t < 3) return 1'b0;
        u = t - 3;
        b = u / BYTE_T;
        r = u % BYTE_T;
        if (b >= img_n) return 1'b0;
        if (r >= 8 * CELL) return 1'b0;
        k = r / CELL;
        c = r % CELL;
        bv = img[b][7-k];
        return (c < PULSE) || (bv && (c >= CELL/2) && (c < CELL/2 + PULSE));
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (tape !== 1'b0) begin fails++; $display("FAIL reset_tape got %b want 0", tape); end
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests_run++;
        if (length !== '0) begin fails++; $display("FAIL reset_length got %0d want 0", length); end
        reset = 1'b0;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_oob_write();
        dn_go = 1'b1;
        tick();
        dn_wr = 1'b1;
        dn_addr = 25'(1 << ADDR_W);
        dn_data = 8'h55;
        tick();
        dn_wr = 1'b0;
        tests_run++;
        if (length !== '0) begin fails++; $display("FAIL oob_length got %0d want 0", length); end
        dn_go = 1'b0;
        tick();
        play = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick();
            tests_run++;
            if (tape !== 1'b0) begin fails++; $display("FAIL oob_tape t=%0d got %b want 0", t, tape); end
        end
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL oob_busy got %b want 0", busy); end
        play = 1'b0;
        tick();
        $display("[TB] out-of-range write and empty play checked");
    endtask

    task automatic test_playback();
        logic e;
        img[0] = 8'hA5; img[1] = 8'h00; img[2] = 8'hFF; img_n = 3;
        dn_go = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            dn_wr = 1'b1;
            dn_addr = 25'(i);
            dn_data = img[i];
            tick();
        end
        dn_wr = 1'b0;
        dn_go = 1'b0;
        tests_run++;
        if (length !== 16'd3) begin fails++; $display("FAIL play_length got %0d want 3", length); end
        tick();
        play = 1'b1;
        for (int t = 0; t <= 395; t++) begin
            tick();
            e = exp_tape(t);
            tests_run++;
            if (tape !== e) begin fails++; $display("FAIL play_tape t=%0d got %b want %b", t, tape, e); end
            if (t == 200) begin
                tests_run++;
                if (busy !== 1'b1) begin fails++; $display("FAIL play_busy t=%0d got %b want 1", t, busy); end
            end
            if (t == 394) begin
                tests_run++;
                if (busy !== 1'b0) begin fails++; $display("FAIL play_busy_end t=%0d got %b want 0", t, busy); end
            end
            if (t == 3 + 3 * BYTE_T - 3) begin
                tests_run++;
                if (done !== 1'b0) begin fails++; $display("FAIL play_done_early t=%0d got %b want 0", t, done); end
            end
            if (t == 3 + 3 * BYTE_T - 2) begin
                tests_run++;
                if (done !== 1'b1) begin fails++; $display("FAIL play_done t=%0d got %b want 1", t, done); end
            end
        end
        $display("[TB] playback A5 00 FF checked");
    endtask

    task automatic test_pause();
        logic e;
        rewind = 1'b1;
        tick();
        tests_run++;
        if (done !== 1'b0) begin fails++; $display("FAIL pause_rewind_done got %b want 0", done); end
        rewind = 1'b0;
        play = 1'b1;
        for (int t = 0; t <= 250; t++) begin
            tick();
            if (t <= 55) e = exp_tape(t);
            else if (t <= 105) e = 1'b0;
            else e = exp_tape(t - 50);
            tests_run++;
            if (tape !== e) begin fails++; $display("FAIL pause_tape t=%0d got %b want %b", t, tape, e); end
            if (t == 80) begin
                tests_run++;
                if (busy !== 1'b1) begin fails++; $display("FAIL pause_busy got %b want 1", busy); end
            end
            if (t == 55) play = 1'b0;
            if (t == 105) play = 1'b1;
        end
        $display("[TB] pause at cnt 5 of bit 3 checked");
    endtask

    task automatic test_new_download();
        logic e;
        dn_go = 1'b1;
        play = 1'b0;
        tick();
        tests_run++;
        if (length !== '0) begin fails++; $display("FAIL newdl_length got %0d want 0", length); end
        tests_run++;
        if (tape !== 1'b0) begin fails++; $display("FAIL newdl_tape got %b want 0", tape); end
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL newdl_busy got %b want 0", busy); end
        img[0] = 8'h3C; img[1] = 8'hC3; img_n = 2;
        for (int i = 0; i < 2; i++) begin
            dn_wr = 1'b1;
            dn_addr = 25'(i);
            dn_data = img[i];
            tick();
        end
        dn_wr = 1'b0;
        dn_go = 1'b0;
        tests_run++;
        if (length !== 16'd2) begin fails++; $display("FAIL newdl_length2 got %0d want 2", length); end
        tick();
        play = 1'b1;
        for (int t = 0; t <= 265; t++) begin
            tick();
            e = exp_tape(t);
            tests_run++;
            if (tape !== e) begin fails++; $display("FAIL newdl_tape t=%0d got %b want %b", t, tape, e); end
            if (t == 3 + 2 * BYTE_T - 2) begin
                tests_run++;
                if (done !== 1'b1) begin fails++; $display("FAIL newdl_done t=%0d got %b want 1", t, done); end
            end
        end
        $display("[TB] new download mid-playback checked");
    endtask

    task automatic test_rewind_done();
        logic e;
        tests_run++;
        if (done !== 1'b1) begin fails++; $display("FAIL rew_done_before got %b want 1", done); end
        rewind = 1'b1;
        tick();
        tests_run++;
        if (done !== 1'b0) begin fails++; $display("FAIL rew_done_fall got %b want 0", done); end
        rewind = 1'b0;
        for (int t = 0; t <= 265; t++) begin
            tick();
            e = exp_tape(t);
            tests_run++;
            if (tape !== e) begin fails++; $display("FAIL rew_tape t=%0d got %b want %b", t, tape, e); end
            if (t == 3 + 2 * BYTE_T - 2) begin
                tests_run++;
                if (done !== 1'b1) begin fails++; $display("FAIL rew_done t=%0d got %b want 1", t, done); end
            end
        end
        $display("[TB] rewind from DONE checked");
    endtask

    task automatic test_reset_mid();
        logic e;
        rewind = 1'b1;
        tick();
        rewind = 1'b0;
        for (int t = 0; t <= 42; t++) begin
            tick();
            e = exp_tape(t);
            tests_run++;
            if (tape !== e) begin fails++; $display("FAIL rst_pre_tape t=%0d got %b want %b", t, tape, e); end
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (tape !== 1'b0) begin fails++; $display("FAIL rst_mid_tape got %b want 0", tape); end
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin fails++; $display("FAIL rst_mid_done got %b want 0", done); end
        tests_run++;
        if (length !== '0) begin fails++; $display("FAIL rst_mid_length got %0d want 0", length); end
        reset = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            tests_run++;
            if ((tape !== 1'b0) || (busy !== 1'b0)) begin
                fails++; $display("FAIL rst_idle t=%0d got tape=%b busy=%b want 0 0", t, tape, busy);
            end
        end
        dn_go = 1'b1;
        tick();
        dn_wr = 1'b1;
        dn_addr = 25'd1;
        dn_data = 8'hC3;
        tick();
        dn_wr = 1'b0;
        dn_go = 1'b0;
        tests_run++;
        if (length !== 16'd2) begin fails++; $display("FAIL rst_relen got %0d want 2", length); end
        for (int t = 0; t <= 150; t++) begin
            tick();
            e = exp_tape(t);
            tests_run++;
            if (tape !== e) begin fails++; $display("FAIL rst_restart_tape t=%0d got %b want %b", t, tape, e); end
        end
        $display("[TB] reset mid-cell and restart checked");
    endtask

    initial begin
        test_reset();
        test_oob_write();
        test_playback();
        test_pause();
        test_new_download();
        test_rewind_done();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/cas_player.md
# cas_player

Cassette playback stage for the Colour Genie core. It captures a `.CAS` image streamed over the HPS download bus into an internal block RAM. On command, it replays the image as a pulse-encoded tape waveform. Its `tape` output feeds the `glue` tape input, in parallel with the ADC tape path, and is selected by the play control.

## Interface
Parameters:
- `ADDR_W`, 15: image RAM address width (32 KiB max image); bytes beyond `2**ADDR_W` are dropped.
- `CELL_CYCLES`, 35714: clock cycles per bit cell (1400 bit/s at 50 MHz).
- `PULSE_CYCLES`, 4000: width of each high pulse in clock cycles; must be less than `CELL_CYCLES/2`.

Ports:
- `clock`, in, 1: system clock; every register is clocked on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `dn_go`, in, 1: download in progress.
- `dn_wr`, in, 1: write strobe for one byte, qualified by `dn_go`.
- `dn_addr`, in, 25: byte address within the image.
- `dn_data`, in, 8: byte to be written.
- `play`, in, 1: level control; 1 = run, 0 = pause.
- `rewind`, in, 1: single-cycle pulse; returns the play pointer to byte 0.
- `tape`, out, 1: encoded tape level.
- `busy`, out, 1: playback active, i.e. the state is FETCH, LOAD or CELL.
- `done`, out, 1: the last bit of the image has been emitted.
- `length`, out, ADDR_W+1: number of bytes held, computed as the highest written address + 1.

## Operation
- Download:
  - A rising edge of `dn_go` clears `length`, and the FSM goes to IDLE immediately.
  - A cycle with `dn_go & dn_wr` writes `dn_data` to RAM at `dn_addr[ADDR_W-1:0]`. It does so only if `dn_addr < 2**ADDR_W`.
  - On that write, `length` becomes `max(length, dn_addr+1)`.
  - While `dn_go=1`, the FSM is held in IDLE, `tape=0`, and the play pointer is 0.
- Encoding:
  - The byte order is ascending address. Within a byte, bits are emitted MSB first.
  - Each bit occupies one cell of `CELL_CYCLES` cycles, counted by `cnt`, which runs from 0 to `CELL_CYCLES-1`.
  - `tape=1` when `cnt < PULSE_CYCLES`; this is the clock pulse.
  - For a 1-bit only, `tape=1` also when `CELL_CYCLES/2 <= cnt < CELL_CYCLES/2 + PULSE_CYCLES`; this is the data pulse.
  - `tape=0` at all other times.
- FSM states:
  - IDLE: `tape=0`. Moves to FETCH when `play=1`, `dn_go=0`, `length>0` and `ptr<length`.
  - FETCH: presents `ptr` to the RAM read port, which is registered with 1-cycle latency. Moves to LOAD.
  - LOAD: latches the RAM output into the shift register and sets `bitn=7`, `cnt=0`. Moves to CELL.
  - CELL: advances `cnt` while `play=1`. At `cnt=CELL_CYCLES-1`:
    - if `bitn>0`: decrement `bitn`, shift left, set `cnt=0`;
    - otherwise `ptr++`, and the FSM moves to FETCH if `ptr+1<length`, or to DONE if not.
  - DONE: `done=1`, `tape=0`. Stays in DONE until `rewind`, reset, or a new download.
- Pause:
  - `play=0` in CELL freezes `cnt`, `bitn`, the shift register and `ptr`, and forces `tape=0`.
  - When `play` returns to 1, the cell resumes at the frozen `cnt`.
  - `play=0` in FETCH or LOAD: the current step completes and the FSM then waits in CELL.
- `rewind` in any state: `ptr=0`, `done=0`, FSM goes to IDLE. `length` and the RAM contents are kept.
- Simultaneous events, in priority order: `reset` > `dn_go` rising edge > `rewind` > `play`.

## Timing
- Reset values: `tape=0`, `busy=0`, `done=0`, `length=0`, `ptr=0`, FSM in IDLE. RAM contents are not cleared.
- Reset applied mid-playback takes effect on the next edge, and `tape` reads 0 from the next cycle.
- `tape`, `busy` and `done` are registered outputs.
- The first rising edge of `tape` occurs 3 cycles after the `play` edge is sampled (IDLE → FETCH → LOAD → CELL with `cnt=0`).
- The inter-byte gap is 2 cycles (FETCH and LOAD, with `tape=0`). A byte therefore takes `8*CELL_CYCLES+2` cycles.
- A write is visible to playback 1 cycle after the `dn_wr` edge. `length` updates in the same cycle.
- `done` rises 1 cycle after the final cell ends.

## Test plan
Use `CELL_CYCLES=16`, `PULSE_CYCLES=3` for all scenarios.
- Download bytes A5, 00, FF at addresses 0–2, then raise `play`. Required:
  - `length=3`;
  - the first `tape` high appears 3 cycles after `play`;
  - the bit pattern is 1,0,1,0,0,1,0,1, with data pulses only in 1-cells at `cnt` 8–10;
  - the 00 byte shows 8 clock pulses only;
  - `done=1` at cycle 3+3·(128+2)−2.
- Drop `play` at `cnt=5` of bit 3 and hold it low for 50 cycles. Required: `tape=0` throughout, and the cell resumes at `cnt=5` with no lost or duplicated bit.
- Start a new download (`dn_go` edge) during byte 1. Required: `tape=0`, `busy=0`, `length` restarts from 0, and a subsequent `play` replays from byte 0 with the new data.
- Assert `reset` mid-cell. Required: outputs at reset values on the next cycle, and `play` held high restarts at byte 0 after `reset` is released.
- Write to address `2**ADDR_W`. Required: ignored, `length` unchanged. Raise `play` with `length=0`: the FSM stays in IDLE and `tape` stays 0.
- In DONE, pulse `rewind` with `play=1`. Required: `done` falls next cycle and the waveform repeats from byte 0.
